rx_addr_filter: RTL and testbench
=================================

Name: rx_addr_filter

Overview:
- Destination-address filter sitting directly downstream of the Ethernet receive path.
- When a frame is reported ready in the receive buffer, it reads the 6-byte destination MAC from buffer words 0–1.
- It classifies the frame against a 14-entry setup-address table plus broadcast, multicast and promiscuous modes.
- Accepted frames are reported to the host side; rejected frames are discarded by driving the receive-done handshake itself.

Parameters:
- NADDR, 14, number of table entries (max 15; index 4'hF is reserved as "no entry").
- AW, 9, receive buffer word-address width.

Ports:
- clk  in  1  block clock, same clock as the receive buffer read port.
- rst_n  in  1  reset, synchronous, active-low.
- rxrdy  in  1  frame-ready level from receive stage; held until receive-done.
- rxcntb  in  11  received frame length in bytes.
- rb_addr  out  AW  receive buffer read address.
- rb_data  in  32  receive buffer read data; valid the cycle after rb_addr is registered.
- tbl_we  in  1  table write strobe.
- tbl_idx  in  4  table entry index.
- tbl_mac  in  48  MAC to store; byte0 (first on wire) in [7:0].
- tbl_en  in  1  valid bit written with the entry.
- promisc  in  1  accept all non-runt frames.
- allmulti  in  1  accept all multicast frames.
- acc_valid  out  1  one-cycle pulse: decision available.
- acc_ok  out  1  frame accepted; valid with acc_valid.
- acc_cls  out  2  0 = runt/none, 1 = unicast, 2 = multicast, 3 = broadcast.
- acc_idx  out  4  matching table index, 4'hF if none.
- drop_done  out  1  receive-done request for rejected frames.
- busy  out  1  high from leaving IDLE until returning to IDLE.

Behaviour:
- Reset: all outputs 0 except acc_idx = 4'hF. Table valid bits are cleared; MAC contents are don't-care. FSM → IDLE.
- Byte order:
  - DA = {word1[15:0], word0[31:0]}; byte0 = word0[7:0].
  - Multicast ⇔ byte0[0] = 1.
  - Broadcast ⇔ DA = 48'hFFFF_FFFF_FFFF.
- Table write:
  - On tbl_we with tbl_idx < NADDR: entry[tbl_idx] ← tbl_mac and valid[tbl_idx] ← tbl_en.
  - tbl_idx ≥ NADDR: ignored.
  - Writes are accepted in every state. A scan in progress compares entry i against its contents in the cycle i is examined.
- FSM:
  - IDLE: busy = 0, rb_addr = 0.
    - On rxrdy = 1 and rxcntb < 14: go to DONE with class 0, reject (runt).
    - On rxrdy = 1 otherwise: go to RD0.
  - RD0: rb_addr = 0 → RD1.
  - RD1: rb_addr = 1; capture word0 → CAP.
  - CAP: capture word1 → CLS.
  - CLS: set class.
    - Broadcast: accept, idx F → DONE.
    - Otherwise, promisc set: accept → SCAN, so the index is still reported.
    - Otherwise: → SCAN with i = 0.
  - SCAN: one entry per cycle.
    - valid[i] and entry[i] == DA: acc_idx ← i, accept → DONE (early exit).
    - i = NADDR−1 with no match: accept only if promisc, or (multicast and allmulti); idx F → DONE.
  - DONE: acc_valid = 1 for exactly one cycle; acc_ok/acc_cls/acc_idx held until the next DONE. Then:
    - accepted → WAIT.
    - rejected → DROP.
  - DROP: drop_done = 1 until rxrdy = 0 is sampled, then drop_done → 0 and go to IDLE.
  - WAIT: hold until rxrdy = 0 (host completes the frame), then go to IDLE.
- Latency, counted from the edge sampling rxrdy in IDLE to the acc_valid cycle:
  - runt: 1 cycle.
  - broadcast: 5 cycles.
  - match at entry i: 6 + i cycles.
  - no match: 5 + NADDR cycles.
- rxrdy falling before DONE (receive stage reset/aborted): complete the decision normally; WAIT/DROP then exit immediately.
- Mode inputs promisc/allmulti are sampled in CLS and the final SCAN cycle only.
- rst_n low in any state → IDLE next edge; drop_done and acc_valid drop immediately at that edge.

Decomposition:
- Shared eth package holds:
  - state encoding.
  - class codes (CLS_NONE/UNI/MULTI/BCAST).
  - BCAST_MAC.
  - MIN_FRAME = 14.
  - NO_IDX = 4'hF.
- One sub-module, mac_table: register array, write port, and combinational compare of the indexed entry against DA returning hit.
- FSM and capture registers stay in rx_addr_filter.

Test Plan:
- Load entry 3 = 08:00:2B:11:22:33 valid. Frame DA = same (word0 = 32'h112B0008, word1[15:0] = 16'h3322), rxcntb = 64 → acc_valid at cycle 9, acc_ok = 1, cls = 1, idx = 3, drop_done stays 0.
- Broadcast frame (word0 = FFFFFFFF, word1 = xxxxFFFF), empty table → acc_valid at cycle 5, ok = 1, cls = 3, idx = F.
- Unicast DA not in table, promisc = 0 → acc_valid at cycle 19, ok = 0, idx = F. drop_done rises the next cycle and is held until rxrdy is driven low 10 cycles later, then falls within 1 cycle; busy = 0 afterwards.
- Multicast DA 01:00:5E:00:00:01: allmulti = 0 → ok = 0, cls = 2; repeat with allmulti = 1 → ok = 1, idx = F.
- rxcntb = 10 → acc_valid at cycle 1, ok = 0, cls = 0, and no buffer read occurs (rb_addr stays 0).
- Write entry 0 with tbl_en = 0 during a scan of a matching DA → no match on entry 0. Separately, assert rst_n = 0 in SCAN → next edge IDLE, all outputs at reset values, table valid bits cleared.

Source files
------------

// File: rtl/rx_addr_filter_pkg.sv
// Shared definitions for the receive destination-address filter.
package rx_addr_filter_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_CAP,
    ST_CLS,
    ST_SCAN,
    ST_DONE,
    ST_DROP,
    ST_WAIT
  } state_e;

  localparam logic [1:0]  CLS_NONE  = 2'd0;
  localparam logic [1:0]  CLS_UNI   = 2'd1;
  localparam logic [1:0]  CLS_MULTI = 2'd2;
  localparam logic [1:0]  CLS_BCAST = 2'd3;

  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam logic [10:0] MIN_FRAME = 11'd14;
  localparam logic [3:0]  NO_IDX    = 4'hF;

  // Group bit is the LSB of the first byte on the wire.
  function automatic logic is_mcast(input logic [47:0] da);
    return da[0];
  endfunction

endpackage

// File: rtl/rx_addr_filter_mac_table.sv
// Setup-address table: per-entry MAC and valid bit, one write port and a
// single combinational compare of the indexed entry against the captured DA.
module mac_table #(
  parameter int NADDR = 14
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [3:0]  widx_i,
  input  logic [47:0] wmac_i,
  input  logic        wen_i,
  input  logic [3:0]  ridx_i,
  input  logic [47:0] da_i,
  output logic        hit_o
);

  localparam logic [3:0] NADDR_W = 4'(NADDR);

  logic [47:0]      mac_q [NADDR];
  logic [NADDR-1:0] valid_q;

  // Valid bits are cleared by reset; out-of-range indices are ignored.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (we_i && (widx_i < NADDR_W)) begin
      valid_q[widx_i] <= wen_i;
    end
  end

  // MAC contents need no reset: an entry is only trusted with its valid bit.
  always_ff @(posedge clk_i) begin
    if (we_i && (widx_i < NADDR_W)) begin
      mac_q[widx_i] <= wmac_i;
    end
  end

  // Compare uses the entry as it stands this cycle, so a write lands for
  // every index not yet examined by a running scan.
  always_comb begin
    hit_o = 1'b0;
    if (ridx_i < NADDR_W) begin
      hit_o = valid_q[ridx_i] && (mac_q[ridx_i] == da_i);
    end
  end

endmodule

// File: rtl/rx_addr_filter.sv
// Destination-address filter: reads the DA from receive buffer words 0-1,
// classifies it against the setup table and modes, reports accepted frames
// and completes rejected frames itself via drop_done.
//
// state | meaning
// IDLE  | waiting for rxrdy; runt frames decided here directly
// RD0   | word 0 address on the buffer port
// RD1   | word 1 address on the buffer port, word 0 captured
// CAP   | word 1 captured, DA complete
// CLS   | broadcast check, class and promisc sampled
// SCAN  | one table entry per cycle, early exit on hit
// DONE  | acc_valid pulse
// DROP  | rejected frame: drop_done until rxrdy falls
// WAIT  | accepted frame: host owns it until rxrdy falls
module rx_addr_filter
  import rx_addr_filter_pkg::*;
#(
  parameter int NADDR = 14,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rxrdy,
  input  logic [10:0]   rxcntb,
  output logic [AW-1:0] rb_addr,
  input  logic [31:0]   rb_data,
  input  logic          tbl_we,
  input  logic [3:0]    tbl_idx,
  input  logic [47:0]   tbl_mac,
  input  logic          tbl_en,
  input  logic          promisc,
  input  logic          allmulti,
  output logic          acc_valid,
  output logic          acc_ok,
  output logic [1:0]    acc_cls,
  output logic [3:0]    acc_idx,
  output logic          drop_done,
  output logic          busy
);

  localparam logic [3:0] LAST_IDX = 4'(NADDR - 1);

  state_e        state_q;
  logic [AW-1:0] rb_addr_q;
  logic [31:0]   word0_q;
  logic [47:0]   da_q;
  logic [3:0]    scan_idx_q;
  logic [1:0]    cls_q;
  logic          prom_q;
  logic          acc_valid_q;
  logic          acc_ok_q;
  logic [1:0]    acc_cls_q;
  logic [3:0]    acc_idx_q;
  logic          drop_done_q;
  logic          busy_q;
  logic          hit;

  mac_table #(
    .NADDR (NADDR)
  ) u_mac_table (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .we_i   (tbl_we),
    .widx_i (tbl_idx),
    .wmac_i (tbl_mac),
    .wen_i  (tbl_en),
    .ridx_i (scan_idx_q),
    .da_i   (da_q),
    .hit_o  (hit)
  );

  // Filter FSM with all outputs registered; decision outputs only change on
  // entry to DONE so they stay stable for the host between frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rb_addr_q   <= '0;
      word0_q     <= '0;
      da_q        <= '0;
      scan_idx_q  <= '0;
      cls_q       <= CLS_NONE;
      prom_q      <= 1'b0;
      acc_valid_q <= 1'b0;
      acc_ok_q    <= 1'b0;
      acc_cls_q   <= CLS_NONE;
      acc_idx_q   <= NO_IDX;
      drop_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      acc_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rxrdy) begin
            busy_q <= 1'b1;
            if (rxcntb < MIN_FRAME) begin
              state_q     <= ST_DONE;
              acc_valid_q <= 1'b1;
              acc_ok_q    <= 1'b0;
              acc_cls_q   <= CLS_NONE;
              acc_idx_q   <= NO_IDX;
            end else begin
              state_q <= ST_RD0;
            end
          end
        end
        ST_RD0: begin
          rb_addr_q <= AW'(1);
          state_q   <= ST_RD1;
        end
        ST_RD1: begin
          rb_addr_q <= '0;
          word0_q   <= rb_data;
          state_q   <= ST_CAP;
        end
        ST_CAP: begin
          da_q    <= {rb_data[15:0], word0_q};
          state_q <= ST_CLS;
        end
        ST_CLS: begin
          prom_q     <= promisc;
          scan_idx_q <= '0;
          if (da_q == BCAST_MAC) begin
            state_q     <= ST_DONE;
            acc_valid_q <= 1'b1;
            acc_ok_q    <= 1'b1;
            acc_cls_q   <= CLS_BCAST;
            acc_idx_q   <= NO_IDX;
          end else begin
            cls_q   <= is_mcast(da_q) ? CLS_MULTI : CLS_UNI;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (hit) begin
            state_q     <= ST_DONE;
            acc_valid_q <= 1'b1;
            acc_ok_q    <= 1'b1;
            acc_cls_q   <= cls_q;
            acc_idx_q   <= scan_idx_q;
          end else if (scan_idx_q == LAST_IDX) begin
            state_q     <= ST_DONE;
            acc_valid_q <= 1'b1;
            acc_ok_q    <= prom_q || promisc || ((cls_q == CLS_MULTI) && allmulti);
            acc_cls_q   <= cls_q;
            acc_idx_q   <= NO_IDX;
          end else begin
            scan_idx_q <= scan_idx_q + 4'd1;
          end
        end
        ST_DONE: begin
          state_q     <= acc_ok_q ? ST_WAIT : ST_DROP;
          drop_done_q <= !acc_ok_q;
        end
        ST_DROP: begin
          if (!rxrdy) begin
            drop_done_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!rxrdy) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          drop_done_q <= 1'b0;
          busy_q      <= 1'b0;
          rb_addr_q   <= '0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rb_addr   = rb_addr_q;
  assign acc_valid = acc_valid_q;
  assign acc_ok    = acc_ok_q;
  assign acc_cls   = acc_cls_q;
  assign acc_idx   = acc_idx_q;
  assign drop_done = drop_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rx_addr_filter.sv
// Bench for rx_addr_filter: directed scenarios plus randomized frames
// checked against a table-lookup reference model.
module tb_rx_addr_filter;

  localparam int NADDR = 14;
  localparam int AW    = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rxrdy = 1'b0;
  logic [10:0]   rxcntb = '0;
  logic [AW-1:0] rb_addr;
  logic [31:0]   rb_data;
  logic          tbl_we = 1'b0;
  logic [3:0]    tbl_idx = '0;
  logic [47:0]   tbl_mac = '0;
  logic          tbl_en = 1'b0;
  logic          promisc = 1'b0;
  logic          allmulti = 1'b0;
  logic          acc_valid;
  logic          acc_ok;
  logic [1:0]    acc_cls;
  logic [3:0]    acc_idx;
  logic          drop_done;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] buf_w0 = '0;
  logic [31:0] buf_w1 = '0;

  // reference table state
  logic [47:0] m_mac [16];
  bit          m_v   [16];

  rx_addr_filter #(.NADDR(NADDR), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxrdy     (rxrdy),
    .rxcntb    (rxcntb),
    .rb_addr   (rb_addr),
    .rb_data   (rb_data),
    .tbl_we    (tbl_we),
    .tbl_idx   (tbl_idx),
    .tbl_mac   (tbl_mac),
    .tbl_en    (tbl_en),
    .promisc   (promisc),
    .allmulti  (allmulti),
    .acc_valid (acc_valid),
    .acc_ok    (acc_ok),
    .acc_cls   (acc_cls),
    .acc_idx   (acc_idx),
    .drop_done (drop_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // synchronous-read receive buffer holding the current frame's first words
  always @(posedge clk)
    rb_data <= (rb_addr == 0) ? buf_w0 : (rb_addr == 1) ? buf_w1 : 32'hDEAD_BEEF;

  // Reference decision straight from the filter rules.
  function automatic void model(input logic [47:0] da, input logic [10:0] len,
                                input bit prom, input bit am,
                                output int lat, output bit ok,
                                output logic [1:0] cls, output logic [3:0] idx);
    lat = 5 + NADDR; ok = 0; cls = 2'd0; idx = 4'hF;
    if (len < 14) begin
      lat = 1;
      return;
    end
    if (da == 48'hFFFF_FFFF_FFFF) begin
      lat = 5; ok = 1; cls = 2'd3;
      return;
    end
    cls = da[0] ? 2'd2 : 2'd1;
    for (int i = 0; i < NADDR; i++) begin
      if (m_v[i] && m_mac[i] == da) begin
        lat = 6 + i; ok = 1; idx = 4'(i);
        return;
      end
    end
    ok = prom || (da[0] && am);
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; rxrdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) m_v[i] = 0;
  endtask

  task automatic tbl_write(input logic [3:0] idx, input logic [47:0] mac, input bit en);
    tbl_we = 1'b1; tbl_idx = idx; tbl_mac = mac; tbl_en = en;
    @(posedge clk); #1;
    tbl_we = 1'b0;
    if (idx < NADDR) begin
      m_mac[idx] = mac; m_v[idx] = en;
    end
  endtask

  // Starts a frame from IDLE and waits (bounded) for the decision pulse.
  task automatic run_frame(input logic [31:0] w0, input logic [31:0] w1, input logic [10:0] len,
                           output int lat, output logic ok, output logic [1:0] cls,
                           output logic [3:0] idx, output bit rbnz);
    buf_w0 = w0; buf_w1 = w1; rxcntb = len; rxrdy = 1'b1;
    lat = -1; ok = 1'bx; cls = 'x; idx = 'x; rbnz = 0;
    for (int n = 1; n <= 60 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (rb_addr != 0) rbnz = 1;
      if (acc_valid) begin
        lat = n; ok = acc_ok; cls = acc_cls; idx = acc_idx;
      end
    end
  endtask

  task automatic end_frame(output bit timeout);
    rxrdy = 1'b0; timeout = 1;
    for (int n = 0; n < 10 && timeout; n++) begin
      @(posedge clk); #1;
      if (!busy) timeout = 0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_acc_valid: got %b expected 0", acc_valid); end
    n_checks++; if (acc_ok !== 1'b0) begin n_fail++; $display("FAIL reset_acc_ok: got %b expected 0", acc_ok); end
    n_checks++; if (acc_cls !== 2'd0) begin n_fail++; $display("FAIL reset_acc_cls: got %0d expected 0", acc_cls); end
    n_checks++; if (acc_idx !== 4'hF) begin n_fail++; $display("FAIL reset_acc_idx: got %h expected f", acc_idx); end
    n_checks++; if (drop_done !== 1'b0) begin n_fail++; $display("FAIL reset_drop_done: got %b expected 0", drop_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (rb_addr !== '0) begin n_fail++; $display("FAIL reset_rb_addr: got %0d expected 0", rb_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_broadcast();
    int lat, e_lat; logic ok; logic [1:0] cls; logic [3:0] idx; bit rbnz, to;
    bit e_ok; logic [1:0] e_cls; logic [3:0] e_idx;
    model(48'hFFFF_FFFF_FFFF, 11'd64, 0, 0, e_lat, e_ok, e_cls, e_idx);
    run_frame(32'hFFFF_FFFF, 32'hA5A5_FFFF, 11'd64, lat, ok, cls, idx, rbnz);
    n_checks++; if (lat !== e_lat) begin n_fail++; $display("FAIL bcast_latency: got %0d expected %0d", lat, e_lat); end
    n_checks++; if (ok !== e_ok || cls !== e_cls || idx !== e_idx) begin n_fail++;
      $display("FAIL bcast_decision: got ok=%b cls=%0d idx=%h expected ok=%b cls=%0d idx=%h", ok, cls, idx, e_ok, e_cls, e_idx); end
    end_frame(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL bcast_idle: busy still 1 expected 0"); end
  endtask

  task automatic test_runt();
    int lat; logic ok; logic [1:0] cls; logic [3:0] idx; bit rbnz, to;
    run_frame(32'h1111_2222, 32'h0000_3333, 11'd10, lat, ok, cls, idx, rbnz);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL runt_latency: got %0d expected 1", lat); end
    n_checks++; if (ok !== 1'b0 || cls !== 2'd0 || idx !== 4'hF) begin n_fail++;
      $display("FAIL runt_decision: got ok=%b cls=%0d idx=%h expected ok=0 cls=0 idx=f", ok, cls, idx); end
    @(posedge clk); #1;
    if (rb_addr != 0) rbnz = 1;
    n_checks++; if (rbnz !== 1'b0) begin n_fail++; $display("FAIL runt_no_read: rb_addr moved=%b expected 0", rbnz); end
    n_checks++; if (drop_done !== 1'b1) begin n_fail++; $display("FAIL runt_drop: got %b expected 1", drop_done); end
    end_frame(to);
    n_checks++; if (to || drop_done !== 1'b0) begin n_fail++; $display("FAIL runt_release: timeout=%b drop_done=%b expected 0 0", to, drop_done); end
  endtask

  task automatic test_match();
    int lat, e_lat; logic ok; logic [1:0] cls; logic [3:0] idx; bit rbnz, to;
    bit e_ok; logic [1:0] e_cls; logic [3:0] e_idx;
    tbl_write(4'd3, 48'h3322_112B_0008, 1);
    model(48'h3322_112B_0008, 11'd64, 0, 0, e_lat, e_ok, e_cls, e_idx);
    run_frame(32'h112B_0008, 32'h7777_3322, 11'd64, lat, ok, cls, idx, rbnz);
    n_checks++; if (lat !== e_lat) begin n_fail++; $display("FAIL match_latency: got %0d expected %0d", lat, e_lat); end
    n_checks++; if (ok !== e_ok || cls !== e_cls || idx !== e_idx) begin n_fail++;
      $display("FAIL match_decision: got ok=%b cls=%0d idx=%h expected ok=%b cls=%0d idx=%h", ok, cls, idx, e_ok, e_cls, e_idx); end
    @(posedge clk); #1;
    n_checks++; if (acc_valid !== 1'b0 || drop_done !== 1'b0) begin n_fail++;
      $display("FAIL match_after: got acc_valid=%b drop_done=%b expected 0 0", acc_valid, drop_done); end
    end_frame(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL match_idle: busy still 1 expected 0"); end
  endtask

  task automatic test_nomatch_drop();
    int lat, e_lat; logic ok; logic [1:0] cls; logic [3:0] idx; bit rbnz, held;
    bit e_ok; logic [1:0] e_cls; logic [3:0] e_idx;
    model(48'h6655_4433_2210, 11'd100, 0, 0, e_lat, e_ok, e_cls, e_idx);
    run_frame(32'h4433_2210, 32'h0000_6655, 11'd100, lat, ok, cls, idx, rbnz);
    n_checks++; if (lat !== e_lat) begin n_fail++; $display("FAIL nomatch_latency: got %0d expected %0d", lat, e_lat); end
    n_checks++; if (ok !== e_ok || cls !== e_cls || idx !== e_idx) begin n_fail++;
      $display("FAIL nomatch_decision: got ok=%b cls=%0d idx=%h expected ok=%b cls=%0d idx=%h", ok, cls, idx, e_ok, e_cls, e_idx); end
    held = 1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (drop_done !== 1'b1) held = 0;
    end
    n_checks++; if (!held) begin n_fail++; $display("FAIL nomatch_drop_held: drop_done dropped early expected 1"); end
    rxrdy = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (drop_done !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL nomatch_release: got drop_done=%b busy=%b expected 0 0", drop_done, busy); end
  endtask

  task automatic test_multicast();
    int lat, e_lat; logic ok; logic [1:0] cls; logic [3:0] idx; bit rbnz, to;
    bit e_ok; logic [1:0] e_cls; logic [3:0] e_idx;
    for (int am = 0; am < 2; am++) begin
      allmulti = am[0];
      model(48'h0100_005E_0001, 11'd64, 0, am[0], e_lat, e_ok, e_cls, e_idx);
      run_frame(32'h005E_0001, 32'h0000_0100, 11'd64, lat, ok, cls, idx, rbnz);
      n_checks++; if (lat !== e_lat || ok !== e_ok || cls !== e_cls || idx !== e_idx) begin n_fail++;
        $display("FAIL mcast_allmulti%0d: got lat=%0d ok=%b cls=%0d idx=%h expected lat=%0d ok=%b cls=%0d idx=%h",
                 am, lat, ok, cls, idx, e_lat, e_ok, e_cls, e_idx); end
      @(posedge clk); #1;
      n_checks++; if (drop_done !== !e_ok) begin n_fail++; $display("FAIL mcast_drop%0d: got %b expected %b", am, drop_done, !e_ok); end
      end_frame(to);
    end
    allmulti = 1'b0;
  endtask

  task automatic test_write_during_scan();
    int lat; logic ok; logic [3:0] idx;
    logic [47:0] da = 48'h0ABC_1234_5678;
    apply_reset();
    tbl_write(4'd0, da, 1);
    buf_w0 = da[31:0]; buf_w1 = {16'h0, da[47:32]}; rxcntb = 11'd60; rxrdy = 1'b1;
    lat = -1; ok = 1'bx; idx = 'x;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk); #1;
      tbl_we = 1'b0;
      if (n == 4) begin tbl_we = 1'b1; tbl_idx = 4'd0; tbl_mac = da; tbl_en = 1'b0; end
      if (n == 5) begin tbl_we = 1'b1; tbl_idx = 4'd5; tbl_mac = da; tbl_en = 1'b1; end
      if (acc_valid) begin lat = n; ok = acc_ok; idx = acc_idx; end
    end
    tbl_we = 1'b0;
    m_v[0] = 0; m_mac[5] = da; m_v[5] = 1;
    n_checks++; if (lat !== 11 || ok !== 1'b1 || idx !== 4'd5) begin n_fail++;
      $display("FAIL scan_write: got lat=%0d ok=%b idx=%h expected lat=11 ok=1 idx=5", lat, ok, idx); end
    rxrdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_in_scan();
    int lat, e_lat; logic ok; logic [1:0] cls; logic [3:0] idx; bit rbnz, to;
    bit e_ok; logic [1:0] e_cls; logic [3:0] e_idx;
    tbl_write(4'd2, 48'h2222_3333_4444, 1);
    buf_w0 = 32'h9999_8888; buf_w1 = 32'h0000_7776; rxcntb = 11'd80; rxrdy = 1'b1;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0 || acc_valid !== 1'b0 || drop_done !== 1'b0 || acc_idx !== 4'hF || acc_ok !== 1'b0 || rb_addr !== '0) begin
      n_fail++; $display("FAIL scan_reset_outputs: got busy=%b valid=%b drop=%b idx=%h ok=%b expected 0 0 0 f 0",
                         busy, acc_valid, drop_done, acc_idx, acc_ok); end
    rst_n = 1'b1; rxrdy = 1'b0;
    for (int i = 0; i < 16; i++) m_v[i] = 0;
    @(posedge clk); #1;
    model(48'h2222_3333_4444, 11'd80, 0, 0, e_lat, e_ok, e_cls, e_idx);
    run_frame(32'h3333_4444, 32'h0000_2222, 11'd80, lat, ok, cls, idx, rbnz);
    n_checks++; if (lat !== e_lat || ok !== e_ok || idx !== e_idx) begin n_fail++;
      $display("FAIL scan_reset_table: got lat=%0d ok=%b idx=%h expected lat=%0d ok=%b idx=%h", lat, ok, idx, e_lat, e_ok, e_idx); end
    end_frame(to);
  endtask

  task automatic test_random();
    int lat, e_lat; logic ok; logic [1:0] cls; logic [3:0] idx; bit rbnz, to;
    bit e_ok; logic [1:0] e_cls; logic [3:0] e_idx;
    logic [47:0] da; logic [10:0] len; int kind, k;
    for (int f = 0; f < 30; f++) begin
      for (int w = 0; w < 2; w++)
        tbl_write(4'($urandom_range(0, 15)), {16'($urandom()), 32'($urandom())}, bit'($urandom_range(0, 3) != 0));
      kind = $urandom_range(0, 4);
      k = $urandom_range(0, NADDR - 1);
      case (kind)
        0: da = m_mac[k];
        1: da = 48'hFFFF_FFFF_FFFF;
        2: da = {16'($urandom()), 32'($urandom())} | 48'h1;
        default: da = {16'($urandom()), 32'($urandom())} & ~48'h1;
      endcase
      if ($isunknown(da)) da = 48'h0000_0000_0002;
      len = (kind == 4) ? 11'($urandom_range(0, 13)) : 11'($urandom_range(14, 1518));
      promisc  = ($urandom_range(0, 4) == 0);
      allmulti = ($urandom_range(0, 2) == 0);
      model(da, len, promisc, allmulti, e_lat, e_ok, e_cls, e_idx);
      run_frame(da[31:0], {16'($urandom()), da[47:32]}, len, lat, ok, cls, idx, rbnz);
      n_checks++; if (lat !== e_lat || ok !== e_ok || cls !== e_cls || idx !== e_idx) begin n_fail++;
        $display("FAIL random_frame%0d: got lat=%0d ok=%b cls=%0d idx=%h expected lat=%0d ok=%b cls=%0d idx=%h",
                 f, lat, ok, cls, idx, e_lat, e_ok, e_cls, e_idx); end
      @(posedge clk); #1;
      n_checks++; if (drop_done !== !e_ok) begin n_fail++; $display("FAIL random_drop%0d: got %b expected %b", f, drop_done, !e_ok); end
      end_frame(to);
      n_checks++; if (to) begin n_fail++; $display("FAIL random_idle%0d: busy still 1 expected 0", f); end
    end
    promisc = 1'b0; allmulti = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin m_mac[i] = '0; m_v[i] = 0; end
    @(posedge clk); #1;
    test_reset();
    test_broadcast();
    test_runt();
    test_match();
    test_nomatch_drop();
    test_multicast();
    test_write_during_scan();
    test_reset_in_scan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
